// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: control inputs from hazard/EX, instruction memory
// port and the IF/ID pipeline register outputs.
//   master : seen by fetch_stage (drives imem_addr and IF/ID fields)
//   slave  : seen by the surrounding pipeline / memory
// Optional macro FETCH_MISALIGN_TRAP_EN adds if_id_misalign.
interface fetch_stage_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        if_id_misalign;

   modport master (
      input  stall, redirect, redirect_target, imem_instr,
      output imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
             if_id_misalign
   );
   modport slave (
      output stall, redirect, redirect_target, imem_instr,
      input  imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
             if_id_misalign
   );
`else
   modport master (
      input  stall, redirect, redirect_target, imem_instr,
      output imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid
   );
   modport slave (
      output stall, redirect, redirect_target, imem_instr,
      input  imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid
   );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction memory and fills the IF/ID pipeline register.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_stage_if.master (stall, redirect, redirect_target,
//          imem_addr, imem_instr, if_id_pc/pc4/instr/valid[/misalign])
// Edge priority: redirect > stall > normal advance.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets are
// delivered to decode as a valid NOP entry flagged if_id_misalign.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic         clk,
   input  logic         rst,
   fetch_stage_if.master bus
);

   localparam logic [31:0] PC_STEP = 32'd4;

   logic [31:0] pc_q,       pc_d;
   logic [31:0] if_pc_q,    if_pc_d;
   logic [31:0] if_pc4_q,   if_pc4_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        if_valid_q, if_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        if_mis_q,   if_mis_d;
   logic        pend_q,     pend_d;   // misaligned redirect awaiting delivery
   logic [31:0] pend_tgt_q, pend_tgt_d;
`endif

   // Next-state selection
   always_comb begin
      pc_d       = pc_q;
      if_pc_d    = if_pc_q;
      if_pc4_d   = if_pc4_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
      if_mis_d   = if_mis_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
`endif
      if (bus.redirect) begin
         // Fetch always proceeds from a word-aligned address
         pc_d       = bus.redirect_target & ~32'd3;
         if_pc_d    = 32'd0;
         if_pc4_d   = 32'd0;
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         if_mis_d   = 1'b0;
         pend_d     = (bus.redirect_target[1:0] != 2'b00);
         pend_tgt_d = bus.redirect_target;
`endif
      end else if (!bus.stall) begin
         pc_d       = pc_q + PC_STEP;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (pend_q) begin
            // Hand decode the raw target so it can raise the trap
            if_pc_d    = pend_tgt_q;
            if_pc4_d   = pend_tgt_q + PC_STEP;
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b1;
            if_mis_d   = 1'b1;
            pend_d     = 1'b0;
         end else begin
            if_pc_d    = pc_q;
            if_pc4_d   = pc_q + PC_STEP;
            if_instr_d = bus.imem_instr;
            if_valid_d = 1'b1;
            if_mis_d   = 1'b0;
         end
`else
         if_pc_d    = pc_q;
         if_pc4_d   = pc_q + PC_STEP;
         if_instr_d = bus.imem_instr;
         if_valid_d = 1'b1;
`endif
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         if_pc_q    <= 32'd0;
         if_pc4_q   <= 32'd0;
         if_instr_q <= NOP_INSTR;
         if_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         if_mis_q   <= 1'b0;
         pend_q     <= 1'b0;
         pend_tgt_q <= 32'd0;
`endif
      end else begin
         pc_q       <= pc_d;
         if_pc_q    <= if_pc_d;
         if_pc4_q   <= if_pc4_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         if_mis_q   <= if_mis_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
`endif
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.if_id_pc    = if_pc_q;
   assign bus.if_id_pc4   = if_pc4_q;
   assign bus.if_id_instr = if_instr_q;
   assign bus.if_id_valid = if_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
   assign bus.if_id_misalign = if_mis_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the 5-stage pipeline.
- Owns the program counter and drives the address of the combinational instruction memory.
- Captures the returned word, with its PC and PC+4, into the IF/ID pipeline register consumed by decode.
- Handles pipeline stalls (hazard unit) and control-flow redirects (branch/jump resolution in EX), flushing the wrong-path instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0) placed in IF/ID on reset/flush

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID contents
redirect  input  1  EX: taken branch / JAL / JALR; load redirect_target
redirect_target  input  32  next PC when redirect=1
imem_addr  output  32  byte address to instruction memory (word index = addr>>2, read combinationally)
imem_instr  input  32  instruction word returned by memory in the same cycle
if_id_pc  output  32  PC of instruction held in IF/ID
if_id_pc4  output  32  if_id_pc + 4 (link value for JAL/JALR)
if_id_instr  output  32  instruction held in IF/ID
if_id_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- Reset (async, rst=1, takes effect immediately):
  - pc = RESET_PC
  - if_id_pc = 0, if_id_pc4 = 0, if_id_instr = NOP_INSTR, if_id_valid = 0
- Fetch:
  - imem_addr = pc, combinational.
  - imem_instr is sampled at the same rising edge that advances pc.
  - Latency: an instruction appears in IF/ID one cycle after its PC is presented.
- Per rising edge (rst=0), priority redirect > stall > normal:
  - redirect=1: pc <= redirect_target; IF/ID <= {pc=0, pc4=0, instr=NOP_INSTR, valid=0}. Flushes the wrong-path fetch. Overrides stall.
  - stall=1, redirect=0: pc and all IF/ID fields hold their values.
  - otherwise: pc <= pc + 4; IF/ID <= {pc, pc+4, imem_instr, 1}.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. No carry-out and no error.
- Alignment: without the optional feature, bits [1:0] of redirect_target are cleared before loading pc, so pc[1:0] is always 2'b00.
- Reset released mid-stall: the first edge after release obeys stall (holds RESET_PC with a bubble in IF/ID).
- Back-to-back redirects: each one loads a new target and keeps if_id_valid=0. No instruction from a redirected-away path ever reaches IF/ID with valid=1.
- Memory content is not checked; X/uninitialised words propagate as-is.
- All outputs are registered except imem_addr, which is taken directly from the pc register.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port if_id_misalign (1 bit). Reset value 0; cleared on stall-free normal advance.
  - A redirect with redirect_target[1:0] != 0 loads pc = {target[31:2],2'b00}.
  - The next non-stalled edge loads IF/ID with {pc=redirect_target unmodified, pc4=target+4, instr=NOP_INSTR, valid=1, misalign=1} instead of the fetched word. Decode raises an instruction-address-misaligned trap from this entry.
  - The misalign flag is held under stall and cleared by a later redirect.
- Undefined: no port; target[1:0] is silently cleared as described in Behaviour.

Test Plan:
- Reset then run 3 cycles with imem word[0..2] = 32'h002081B3, 32'h40418333, 32'h00F3F413 -> IF/ID shows pc 0/4/8, pc4 4/8/C, matching instr, valid=1 from the 1st post-reset edge.
- Assert rst asynchronously mid-run at pc=32'h10 -> outputs reset immediately without a clock edge: pc=RESET_PC, if_id_instr=32'h00000013, valid=0.
- stall=1 for 2 cycles at pc=8 -> imem_addr stays 8 and IF/ID frozen; after release the next edge captures pc=8.
- redirect=1 with target 32'h80 while stall=1 at pc=32'h34 -> next cycle imem_addr=32'h80, valid=0, instr=NOP; following edge captures pc=32'h80, valid=1.
- Preload pc near top via redirect target 32'hFFFFFFFC, run 2 edges -> IF/ID pc=32'hFFFFFFFC, pc4=0; imem_addr wraps to 0.
- Redirect to 32'h102 -> without macro imem_addr=32'h100 and valid entry follows; with FETCH_MISALIGN_TRAP_EN, if_id_misalign=1, if_id_pc=32'h102, instr=NOP.
